// File: rtl/pps_framer.sv
// pps_framer: reassembles the 4-byte PPS count burst and splices it as a tagged
// 3-word packet (header, count hi, count lo) into the zero-extended ADC sample stream.
module pps_framer #(
    parameter logic [3:0] TAG = 4'hA
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [7:0]  pps_data,
    input  logic        pps_valid,
    input  logic [11:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        PASS = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [1:0]  idx_r;
    logic [23:0] asm_r;
    logic [31:0] pend_count_r;
    logic [31:0] tx_count_r;
    logic        pend_r;
    logic        pend_ovr_r;
    logic [7:0]  seq_r;
    logic [15:0] out_data_r;
    logic        out_valid_r;

    logic        ld_s;
    logic        capture_s;
    logic        hdr_ld_s;
    logic        lo_ld_s;
    logic [15:0] out_data_nxt_s;
    logic        out_valid_nxt_s;

    assign ld_s      = !out_valid_r || out_ready;
    assign capture_s = pps_valid && (idx_r == 2'd3);
    assign s_ready   = nreset && (state_r == PASS) && !pend_r && ld_s;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;

    // Byte assembler: bytes 0..2 collect the upper 24 bits, byte 3 completes the capture
    always_ff @(posedge clk) begin
        if (!nreset) begin
            idx_r <= 2'd0;
            asm_r <= 24'h000000;
        end else if (pps_valid) begin
            idx_r <= idx_r + 2'd1;
            case (idx_r)
                2'd0:    asm_r[23:16] <= pps_data;
                2'd1:    asm_r[15:8]  <= pps_data;
                2'd2:    asm_r[7:0]   <= pps_data;
                default: asm_r        <= asm_r;
            endcase
        end else begin
            idx_r <= 2'd0;
            asm_r <= asm_r;
        end
    end

    // Pending count; a capture landing on the header-load cycle is fresh, not an overrun
    always_ff @(posedge clk) begin
        if (!nreset) begin
            pend_r       <= 1'b0;
            pend_ovr_r   <= 1'b0;
            pend_count_r <= 32'h0000_0000;
        end else if (capture_s) begin
            pend_r       <= 1'b1;
            pend_ovr_r   <= pend_r && !hdr_ld_s;
            pend_count_r <= {asm_r, pps_data};
        end else if (hdr_ld_s) begin
            pend_r       <= 1'b0;
            pend_ovr_r   <= 1'b0;
        end else begin
            pend_r       <= pend_r;
            pend_ovr_r   <= pend_ovr_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_r <= PASS;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic: each packet word advances only when the output register loads
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            PASS: if (ld_s && pend_r) state_nxt_s = HI;   else state_nxt_s = PASS;
            HI:   if (ld_s)           state_nxt_s = LO;   else state_nxt_s = HI;
            LO:   if (ld_s)           state_nxt_s = PASS; else state_nxt_s = LO;
            default:                  state_nxt_s = PASS;
        endcase
    end

    // FSM output logic: selects the next output-register contents
    always_comb begin
        out_data_nxt_s  = out_data_r;
        out_valid_nxt_s = out_valid_r;
        hdr_ld_s        = 1'b0;
        lo_ld_s         = 1'b0;
        case (state_r)
            PASS: begin
                if (ld_s && pend_r) begin
                    hdr_ld_s        = 1'b1;
                    out_data_nxt_s  = {TAG, 3'b000, pend_ovr_r, seq_r};
                    out_valid_nxt_s = 1'b1;
                end else if (ld_s && s_valid) begin
                    out_data_nxt_s  = {4'h0, s_data};
                    out_valid_nxt_s = 1'b1;
                end else if (ld_s) begin
                    out_valid_nxt_s = 1'b0;
                end else begin
                    out_valid_nxt_s = out_valid_r;
                end
            end
            HI: begin
                if (ld_s) begin
                    out_data_nxt_s  = tx_count_r[31:16];
                    out_valid_nxt_s = 1'b1;
                end else begin
                    out_valid_nxt_s = out_valid_r;
                end
            end
            LO: begin
                if (ld_s) begin
                    lo_ld_s         = 1'b1;
                    out_data_nxt_s  = tx_count_r[15:0];
                    out_valid_nxt_s = 1'b1;
                end else begin
                    out_valid_nxt_s = out_valid_r;
                end
            end
            default: begin
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Output register, transmit count snapshot and packet sequence number
    always_ff @(posedge clk) begin
        if (!nreset) begin
            out_data_r  <= 16'h0000;
            out_valid_r <= 1'b0;
            tx_count_r  <= 32'h0000_0000;
            seq_r       <= 8'h00;
        end else begin
            out_data_r  <= out_data_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            tx_count_r  <= hdr_ld_s ? pend_count_r : tx_count_r;
            seq_r       <= lo_ld_s ? (seq_r + 8'd1) : seq_r;
        end
    end

endmodule
